gpu_operand_collector: RTL
==========================

GPU_OPERAND_COLLECTOR -- requirements
Module: gpu_operand_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter CTX_W, default 3, thread-context (register offset) select width covering 8 contexts of 32 registers.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have issue ports: iss_valid in 1; iss_ready out 1; iss_ctx in CTX_W; iss_src_a in 5; iss_src_b in 5; iss_use_b in 1 (second operand needed); iss_dst in 5 (passed through).
REQ-005 SHALL have writeback ports: wb_valid in 1; wb_ctx in CTX_W; wb_reg in 5; wb_data in DATA_W. Writeback has no ready and is always accepted.
REQ-006 SHALL have bank ports: bank_read out 1; bank_write out 1; bank_offset out CTX_W; bank_target_reg out 6, always {1'b0, index}; bank_in out DATA_W; bank_out in DATA_W; bank_valid in 1 (read data valid).
REQ-007 SHALL have execute ports: op_valid out 1; op_ready in 1; op_a out DATA_W; op_b out DATA_W; op_ctx out CTX_W; op_dst out 5.

Function
REQ-008 SHALL implement states IDLE, RD_A, WAIT_A, RD_B, WAIT_B, DONE.
REQ-009 SHALL drive iss_ready=1 only in IDLE; on iss_valid&&iss_ready it SHALL latch ctx/src/use_b/dst and enter RD_A.
REQ-010 In RD_x with no conflicting writeback, it SHALL assert bank_read for exactly one cycle with bank_offset=ctx and bank_target_reg={0,src_x}, then enter WAIT_x.
REQ-011 In WAIT_x it SHALL capture bank_out into op_x on the first cycle bank_valid=1, then go to RD_B if use_b, else DONE; it SHALL wait indefinitely while bank_valid=0.
REQ-012 When use_b=0, op_b SHALL be driven as zero.
REQ-013 wb_valid SHALL assert bank_write, bank_offset=wb_ctx, bank_target_reg={0,wb_reg} and bank_in=wb_data in the same cycle, combinationally, in every state.
REQ-014 bank_read and bank_write SHALL never be asserted together; while wb_valid=1 a collector in RD_x SHALL hold in RD_x, and the read SHALL issue on the next cycle with wb_valid=0.
REQ-015 In DONE it SHALL hold op_valid=1 and all op_* stable until op_ready=1, then return to IDLE; op_valid SHALL be 0 in every other state.
REQ-016 Latency with no writeback and bank_valid one cycle after bank_read: op_valid rises 5 cycles after the issue-accept edge for two sources, 3 cycles for one source.
REQ-017 A new issue SHALL NOT be accepted in the cycle DONE is left; the next accept is earliest one cycle later.

Reset
REQ-018 While rst_n=0 at a clk edge: state=IDLE; op_valid=0; op_a/op_b/op_ctx/op_dst=0; bank_read=0; latched fields=0.
REQ-019 bank_write SHALL be 0 while rst_n=0, even if wb_valid=1.
REQ-020 Reset mid-operation SHALL discard the in-flight operands; a bank_valid arriving after reset SHALL be ignored.

Configuration
REQ-021 With GPU_OPCOLL_BYPASS_EN defined: in RD_x, if wb_valid and wb_ctx==ctx and wb_reg==src_x, it SHALL capture wb_data into op_x and advance directly as from WAIT_x, skipping the bank read.
REQ-022 Without GPU_OPCOLL_BYPASS_EN: behaviour SHALL be per REQ-014 only, with no bypass logic present.

Verification
REQ-023 Reset, then issue ctx=2, a=5, b=7, use_b=1, with bank model returning 0x2_05/0x2_07 -> op_valid at +5 cycles, op_a=0x205, op_b=0x207, bank_offset=2 on both reads.
REQ-024 Issue use_b=0, a=31 -> exactly one bank_read with target 0x1F, op_valid at +3 cycles, op_b=0.
REQ-025 wb_valid held 3 cycles during RD_A -> bank_write for 3 cycles, no bank_read overlap, read issues in the 4th cycle, op_valid delayed by 3.
REQ-026 op_ready=0 for 10 cycles in DONE -> op_* stable, iss_ready=0 throughout; the issue is accepted one cycle after the op_ready handshake.
REQ-027 rst_n=0 asserted in WAIT_B, with a late bank_valid after release -> IDLE, op_valid=0, late data ignored, iss_ready=1.
REQ-028 With GPU_OPCOLL_BYPASS_EN, wb ctx=2 reg=5 data=0xABCD coinciding with RD_A for ctx=2 a=5 -> op_a=0xABCD, no bank_read for A; without the macro -> the read is deferred one cycle, then issued.

Source files
------------

// File: rtl/gpu_operand_collector.sv
// gpu_operand_collector
// Collects one or two source operands for an issued instruction from a banked,
// context-offset register file and presents them to the execute stage.
//
// Optional feature: compile with GPU_OPCOLL_BYPASS_EN defined to let a
// writeback that targets the register currently being collected supply the
// operand directly, skipping that bank read.
//
// Handshake semantics (iss_* and op_*): a transfer happens on a rising clk edge
// where valid and ready are both 1; once valid is raised its payload stays
// stable until that transfer. Writeback has no ready and always wins the bank
// port, so a pending read simply waits in its RD state.
//
// fsm_state is a debug view of the FSM: 0 IDLE, 1 RD_A, 2 WAIT_A, 3 RD_B,
// 4 WAIT_B, 5 DONE.
module gpu_operand_collector #(
  parameter int DATA_W = 64,
  parameter int CTX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [CTX_W-1:0]  iss_ctx,
  input  logic [4:0]        iss_src_a,
  input  logic [4:0]        iss_src_b,
  input  logic              iss_use_b,
  input  logic [4:0]        iss_dst,
  input  logic              wb_valid,
  input  logic [CTX_W-1:0]  wb_ctx,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              bank_read,
  output logic              bank_write,
  output logic [CTX_W-1:0]  bank_offset,
  output logic [5:0]        bank_target_reg,
  output logic [DATA_W-1:0] bank_in,
  input  logic [DATA_W-1:0] bank_out,
  input  logic              bank_valid,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [CTX_W-1:0]  op_ctx,
  output logic [4:0]        op_dst,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_A   = 3'd1,
    WAIT_A = 3'd2,
    RD_B   = 3'd3,
    WAIT_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [CTX_W-1:0] ctx_q;
  logic [4:0]       src_a_q;
  logic [4:0]       src_b_q;
  logic             use_b_q;
  logic [4:0]       dst_q;

  logic             in_rd;
  logic [4:0]       cur_src;

  assign in_rd   = (state == RD_A) || (state == RD_B);
  assign cur_src = (state == RD_B) ? src_b_q : src_a_q;

`ifdef GPU_OPCOLL_BYPASS_EN
  // A writeback to exactly the register being collected can stand in for the read.
  logic byp_hit;
  assign byp_hit = in_rd && wb_valid && (wb_ctx == ctx_q) && (wb_reg == cur_src);
`endif

  // Bank port: writeback owns it whenever present; a read goes out only in RD_x.
  assign iss_ready       = (state == IDLE);
  assign bank_write      = rst_n && wb_valid;
  assign bank_read       = rst_n && in_rd && !wb_valid;
  assign bank_offset     = wb_valid ? wb_ctx : ctx_q;
  assign bank_target_reg = {1'b0, (wb_valid ? wb_reg : cur_src)};
  assign bank_in         = wb_valid ? wb_data : '0;

  assign op_ctx    = ctx_q;
  assign op_dst    = dst_q;
  assign fsm_state = state;

  // Collector FSM: latch the issue, read A then optionally B, hold results until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctx_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      use_b_q  <= 1'b0;
      dst_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iss_valid) begin
            ctx_q   <= iss_ctx;
            src_a_q <= iss_src_a;
            src_b_q <= iss_src_b;
            use_b_q <= iss_use_b;
            dst_q   <= iss_dst;
            // op_b is cleared here so a single-source op presents zero for it.
            op_a    <= '0;
            op_b    <= '0;
            state   <= RD_A;
          end
        end
        RD_A: begin
`ifdef GPU_OPCOLL_BYPASS_EN
          if (byp_hit) begin
            op_a <= wb_data;
            if (use_b_q) begin
              state <= RD_B;
            end else begin
              state    <= DONE;
              op_valid <= 1'b1;
            end
          end else
`endif
          if (!wb_valid) begin
            state <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (bank_valid) begin
            op_a <= bank_out;
            if (use_b_q) begin
              state <= RD_B;
            end else begin
              state    <= DONE;
              op_valid <= 1'b1;
            end
          end
        end
        RD_B: begin
`ifdef GPU_OPCOLL_BYPASS_EN
          if (byp_hit) begin
            op_b     <= wb_data;
            state    <= DONE;
            op_valid <= 1'b1;
          end else
`endif
          if (!wb_valid) begin
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bank_valid) begin
            op_b     <= bank_out;
            state    <= DONE;
            op_valid <= 1'b1;
          end
        end
        DONE: begin
          // Leaving DONE goes through one IDLE cycle before the next accept.
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
